// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a length-prefixed little-endian byte stream, writes one 32-bit word
// per WRITE cycle, then pulses boot_pulse_o and releases the core.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256
// checksum byte that is verified in the CHK state before booting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, core held, waiting for start
// LEN_LO  | waiting for low length byte
// LEN_HI  | waiting for high length byte, range-checks the length
// DATA    | collecting bytes into the current word
// WRITE   | one-cycle instruction memory write strobe
// CHK     | (checksum build only) waiting for the trailer byte
// BOOT    | one-cycle boot pulse, core loads PC from pc_init
// RUN     | load complete, core released
// ERR     | frame rejected, core held
module imem_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_wdata_o,
    output logic        core_hold_o,
    output logic        boot_pulse_o,
    output logic [31:0] pc_init_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_DATA   = 4'd3,
        S_WRITE  = 4'd4,
        S_BOOT   = 4'd5,
        S_RUN    = 4'd6,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK    = 4'd8,
`endif
        S_ERR    = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] len_full;
    logic        byte_fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    // Handshake: a byte moves only when both sides agree on this edge.
    assign byte_fire = byte_valid_i & byte_ready_o;

    // State and datapath registers; reset leaves the core held in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        len_full   = {byte_in_i, len_q[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                // Restart is only honoured outside an active frame.
                if (start_i) begin
                    state_d    = S_LEN_LO;
                    word_idx_d = 16'd0;
                    lane_d     = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            S_LEN_LO: begin
                if (byte_fire) begin
                    len_d[7:0] = byte_in_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_fire) begin
                    len_d = len_full;
                    if ((len_full == 16'd0) || ({16'd0, len_full} > DEPTH_U)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = 16'd0;
                        lane_d     = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (byte_fire) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = byte_in_i;
                    lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + byte_in_i;
`endif
                    if (lane_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                lane_d     = 2'd0;
                if ((word_idx_q + 16'd1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_BOOT;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (byte_fire) begin
                    state_d = (byte_in_i == sum_q) ? S_BOOT : S_ERR;
                end
            end
`endif
            S_BOOT: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode from the registered state so reset clears them at once.
    always_comb begin
        byte_ready_o = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA: byte_ready_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                      byte_ready_o = 1'b1;
`endif
            default:                    byte_ready_o = 1'b0;
        endcase
        im_we_o      = (state_q == S_WRITE);
        im_addr_o    = BOOT_ADDR + {14'd0, word_idx_q, 2'b00};
        im_wdata_o   = wdata_q;
        core_hold_o  = (state_q != S_RUN);
        boot_pulse_o = (state_q == S_BOOT);
        done_o       = (state_q == S_RUN);
        error_o      = (state_q == S_ERR);
        pc_init_o    = BOOT_ADDR;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the datapath only ever reads it.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory, holding the core stalled throughout.
- After a successful load, issues a one-cycle boot pulse so the core loads its PC from the initialize vector (PCsel=11, enPC=1), then releases the core.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in words; upper bound on frame length.
- BOOT_ADDR, 32'h0000_0000, byte address of word 0; driven on pc_init.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction memory write strobe, one cycle per word.
- im_addr  out  32  byte address of the write: BOOT_ADDR + 4*word_idx.
- im_wdata  out  32  assembled word.
- core_hold  out  1  high = force enPC=0, enW=0, write_mem=0 in the core.
- boot_pulse  out  1  one cycle; core uses PCsel=11, enPC=1.
- pc_init  out  32  constant BOOT_ADDR, wired to the datapath initialize input.
- done  out  1  load completed, core running.
- error  out  1  frame rejected, core held.

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, core_hold=1, byte_ready=0, im_we=0, im_addr=BOOT_ADDR, im_wdata=0, boot_pulse=0, done=0, error=0. Internal len, word_idx and lane are cleared to 0.
- A byte is consumed on any rising edge where byte_valid and byte_ready are both high. A byte presented while byte_ready=0 is not consumed; the source holds it.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, BOOT, RUN, ERR.
- IDLE:
  - start -> LEN_LO, with byte_ready=1.
- LEN_LO:
  - Byte consumed -> len[7:0], go to LEN_HI.
- LEN_HI:
  - Byte consumed -> len[15:8].
  - If the 16-bit len is 0 or len > DEPTH_WORDS -> ERR.
  - Otherwise -> DATA with word_idx=0, lane=0.
- DATA:
  - Byte consumed -> im_wdata[8*lane+7:8*lane], then lane++.
  - On the 4th byte (lane==3) -> WRITE.
- WRITE:
  - Lasts exactly one cycle, with im_we=1, im_addr=BOOT_ADDR+(word_idx<<2) and byte_ready=0.
  - On the next edge, word_idx++ and lane=0.
  - If the new word_idx==len -> BOOT, otherwise -> DATA.
  - Latency: im_we is high in the cycle directly after the edge that consumed the 4th byte.
- BOOT:
  - One cycle with boot_pulse=1 and core_hold=1; the core captures pc_init. Then -> RUN.
- RUN:
  - core_hold=0, done=1, byte_ready=0.
  - start -> LEN_LO: core_hold=1 and done=0 on the same edge.
- ERR:
  - error=1, core_hold=1, byte_ready=0.
  - start -> LEN_LO: error=0 on the same edge.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and BOOT. No restart happens mid-frame.
- byte_ready is 1 only in LEN_LO, LEN_HI and DATA (and CHK when that state is compiled in).
- Extra bytes after the final word are not consumed, because byte_ready=0.
- Reset mid-frame: the loader returns to IDLE immediately. Words already written stay in memory, the partial word is discarded, and im_we drops asynchronously.
- word_idx is 16 bits wide; im_addr arithmetic is modulo 2^32.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, the FSM enters CHK instead of BOOT.
  - CHK consumes one trailer byte, which must equal the modulo-256 sum of all 4*len data bytes. Length bytes are excluded from the sum.
  - Match -> BOOT. Mismatch -> ERR; memory keeps the written words but no boot occurs.
  - The running sum clears whenever LEN_LO is entered.
- When undefined:
  - There is no trailer byte and no CHK state; the last WRITE goes directly to BOOT.

Test Plan:
- Basic load: reset, start, stream 02 00 | 13 05 10 00 | 93 05 20 00 -> im_we twice: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593. boot_pulse for one cycle, then done=1 and core_hold=0.
- Backpressure/gaps: same frame with byte_valid low for 3 cycles between every byte -> identical writes. No byte is consumed twice; byte_ready=0 during each WRITE cycle.
- Length errors:
  - len 00 00 -> error=1, core_hold=1, no im_we.
  - len = DEPTH_WORDS+1 -> same result.
  - start then clears error, and a valid frame then loads.
- Reset mid-frame: reset asserted after 6 data bytes -> im_we drops immediately, state returns to IDLE with core_hold=1. A fresh start plus a 1-word frame writes only at addr 0x0.
- Reload from RUN: start while done=1 -> core_hold rises on the same edge. The new 1-word frame (EF BE AD DE) writes 0xDEADBEEF at 0x0, followed by boot_pulse.
- IMEM_LOADER_CHECKSUM_EN:
  - 1-word frame 01 00 | 01 02 03 04 | 0A -> boot and done.
  - The same frame with trailer 0B -> error=1 and no boot_pulse.
